// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select of an N:1 mux (N = 2**m), registered outputs.
// Optional grant timeout compiled in with `define MUX_ARB_TIMEOUT_EN (HOLD_MAX cycles).
module rr_mux_arbiter #(
    parameter int m        = 3,
    parameter int HOLD_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2**m-1:0]   req,
    output logic [m-1:0]      select,
    output logic [2**m-1:0]   gnt,
    output logic              busy
);

    localparam int N = 2**m;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state, state_n;
    logic [m-1:0]   ptr, ptr_n;
    logic [m-1:0]   select_n;
    logic [N-1:0]   gnt_n;
    logic           busy_n;

    logic [m-1:0]   win;
    logic           found;
    logic           timeout;

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_range
        $error("rr_mux_arbiter: HOLD_MAX must be in 1..255");
    end

`ifdef MUX_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt, hold_cnt_n;
    assign timeout = (hold_cnt == 8'(HOLD_MAX));
`else
    assign timeout = 1'b0;
`endif

    // First requester at or after ptr, wrapping through N-1 back to 0.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            logic [m-1:0] idx;
            idx = ptr + m'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        select_n = select;
        gnt_n    = gnt;
        busy_n   = busy;
`ifdef MUX_ARB_TIMEOUT_EN
        hold_cnt_n = hold_cnt;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_n      = GRANT;
                    select_n     = win;
                    gnt_n        = '0;
                    gnt_n[win]   = 1'b1;
                    busy_n       = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
                    hold_cnt_n   = 8'd1;
`endif
                end
            end
            GRANT: begin
                // Request drop and timeout collapse into the same single release.
                if (!req[select] || timeout) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                    ptr_n   = select + 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
                    hold_cnt_n = '0;
`endif
                end else begin
`ifdef MUX_ARB_TIMEOUT_EN
                    hold_cnt_n = hold_cnt + 8'd1;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            select <= '0;
            gnt    <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            select <= select_n;
            gnt    <= gnt_n;
            busy   <= busy_n;
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_cnt <= '0;
        else        hold_cnt <= hold_cnt_n;
    end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (m=3, HOLD_MAX=4); timeout checks follow MUX_ARB_TIMEOUT_EN.
module tb_rr_mux_arbiter;

    localparam int M = 3;
    localparam int N = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] req   = '0;
    logic [M-1:0] sel;
    logic [N-1:0] gnt;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.m(M), .HOLD_MAX(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .select (sel),
        .gnt    (gnt),
        .busy   (busy)
    );

    typedef struct {
        logic [N-1:0] req;
        logic [M-1:0] sel;
        logic [N-1:0] gnt;
        logic         busy;
    } vec_t;

    vec_t vecs[26];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [M-1:0] esel,
                             input logic [N-1:0] egnt, input logic ebusy);
        check8({name, ".select"}, 8'(sel), 8'(esel));
        check8({name, ".gnt"}, gnt, egnt);
        check8({name, ".busy"}, 8'(busy), 8'(ebusy));
        n_checks++;
        if (!$onehot0(gnt) || (busy !== (gnt != '0))) begin
            n_fail++;
            $display("FAIL %s.invariant: got gnt=%h busy=%b expected onehot0 gnt and busy=(gnt!=0)",
                     name, gnt, busy);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] exp_g;

        // req, select, gnt, busy after the edge
        vecs[0]  = '{8'h04, 3'd2, 8'h04, 1'b1};
        vecs[1]  = '{8'h00, 3'd2, 8'h00, 1'b0};
        vecs[2]  = '{8'h00, 3'd2, 8'h00, 1'b0};
        vecs[3]  = '{8'h40, 3'd6, 8'h40, 1'b1};
        vecs[4]  = '{8'h00, 3'd6, 8'h00, 1'b0};
        vecs[5]  = '{8'h81, 3'd7, 8'h80, 1'b1};
        vecs[6]  = '{8'h01, 3'd7, 8'h00, 1'b0};
        vecs[7]  = '{8'h01, 3'd0, 8'h01, 1'b1};
        vecs[8]  = '{8'h00, 3'd0, 8'h00, 1'b0};
        vecs[9]  = '{8'h22, 3'd1, 8'h02, 1'b1};
        vecs[10] = '{8'h22, 3'd1, 8'h02, 1'b1};
        vecs[11] = '{8'h20, 3'd1, 8'h00, 1'b0};
        vecs[12] = '{8'h22, 3'd5, 8'h20, 1'b1};
        vecs[13] = '{8'h22, 3'd5, 8'h20, 1'b1};
        vecs[14] = '{8'h02, 3'd5, 8'h00, 1'b0};
        vecs[15] = '{8'h22, 3'd1, 8'h02, 1'b1};
        vecs[16] = '{8'h22, 3'd1, 8'h02, 1'b1};
        vecs[17] = '{8'h20, 3'd1, 8'h00, 1'b0};
        vecs[18] = '{8'h22, 3'd5, 8'h20, 1'b1};
        vecs[19] = '{8'h3F, 3'd5, 8'h20, 1'b1};
        vecs[20] = '{8'h20, 3'd5, 8'h20, 1'b1};
        vecs[21] = '{8'h00, 3'd5, 8'h00, 1'b0};
        vecs[22] = '{8'h60, 3'd6, 8'h40, 1'b1};
        vecs[23] = '{8'h20, 3'd6, 8'h00, 1'b0};
        vecs[24] = '{8'h20, 3'd5, 8'h20, 1'b1};
        vecs[25] = '{8'h00, 3'd5, 8'h00, 1'b0};

        // Asynchronous reset before any clock edge
        req = 8'hFF;
        #1 rst_n = 1'b0;
        #2 check_out("reset_async", 3'd0, 8'h00, 1'b0);
        step();
        step();
        check_out("reset_held", 3'd0, 8'h00, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            req = vecs[i].req;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].sel, vecs[i].gnt, vecs[i].busy);
        end

        // Constant req=0x18 from ptr=0: timeout alternates 3 and 4, otherwise 3 holds
        do_reset();
        req = 8'h18;
        for (int c = 0; c < 10; c++) begin
            step();
`ifdef MUX_ARB_TIMEOUT_EN
            exp_g = (c < 4) ? 8'h08 : (c == 4) ? 8'h00 : (c < 9) ? 8'h10 : 8'h00;
`else
            exp_g = 8'h08;
`endif
            check8($sformatf("hold_c%0d.gnt", c), gnt, exp_g);
        end

        // Reset pulse between edges aborts a grant; arbitration restarts at ptr 0
        do_reset();
        req = 8'h20;
        step();
        check_out("pre_abort", 3'd5, 8'h20, 1'b1);
        req = 8'h21;
        #3 rst_n = 1'b0;
        #1 check_out("abort", 3'd0, 8'h00, 1'b0);
        #1 rst_n = 1'b1;
        step();
        check_out("after_abort", 3'd0, 8'h01, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
